// File: rtl/rc_exec_ctrl.sv
// Per-RC execution controller: walks the instruction pointer, commits ALU results
// and flags, holds the RC for multi-cycle multiplies and signals kernel completion.
module rc_exec_ctrl #(
    parameter int DP_WIDTH          = 32,
    parameter int ALU_N_FLAG        = 2,
    parameter int RCS_NUM_CREG      = 32,
    parameter int RCS_NUM_CREG_LOG2 = 5,
    parameter int MULT_STALL_CYCLES = 1
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         start_i,
    input  logic                         exec_en_i,
    input  logic                         end_i,
    input  logic [DP_WIDTH-1:0]          alu_res_i,
    input  logic [ALU_N_FLAG-1:0]        flag_i,
    input  logic                         br_req_i,
    input  logic [RCS_NUM_CREG_LOG2-1:0] br_add_i,
    input  logic                         alu_stall_i,
    output logic [RCS_NUM_CREG_LOG2-1:0] pc_o,
    output logic [DP_WIDTH-1:0]          res_o,
    output logic [ALU_N_FLAG-1:0]        flag_o,
    output logic                         res_valid_o,
    output logic                         stall_o,
    output logic                         busy_o,
    output logic                         done_o
);

    localparam int CNT_W = (MULT_STALL_CYCLES > 1) ? $clog2(MULT_STALL_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULT_STALL_CYCLES - 1);
    localparam logic [RCS_NUM_CREG_LOG2-1:0] PC_LAST = RCS_NUM_CREG_LOG2'(RCS_NUM_CREG - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EXEC  = 2'd1,
        ST_STALL = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                         r_state;
    logic [RCS_NUM_CREG_LOG2-1:0]   r_pc;
    logic [CNT_W-1:0]               r_cnt;
    logic [DP_WIDTH-1:0]            r_res;
    logic [ALU_N_FLAG-1:0]          r_flag;
    logic                           r_res_valid;

    logic                           w_commit;
    logic [RCS_NUM_CREG_LOG2-1:0]   w_pc_inc;

    // A multiply commits only on the last enabled STALL cycle; plain ops commit in EXEC.
    assign w_commit = exec_en_i &&
                      (((r_state == ST_EXEC) && !alu_stall_i) ||
                       ((r_state == ST_STALL) && (r_cnt == '0)));

    assign w_pc_inc = (r_pc == PC_LAST) ? '0 : r_pc + RCS_NUM_CREG_LOG2'(1);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= ST_IDLE;
            r_pc        <= '0;
            r_cnt       <= '0;
            r_res       <= '0;
            r_flag      <= '0;
            r_res_valid <= 1'b0;
        end else begin
            r_res_valid <= w_commit;
            if (w_commit) begin
                r_res  <= alu_res_i;
                r_flag <= flag_i;
                if (end_i) begin
                    r_state <= ST_DONE;
                    r_pc    <= '0;
                end else begin
                    r_state <= ST_EXEC;
                    r_pc    <= br_req_i ? br_add_i : w_pc_inc;
                end
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (start_i) r_state <= ST_EXEC;
                    end
                    ST_EXEC: begin
                        if (exec_en_i && alu_stall_i) begin
                            r_cnt   <= CNT_LOAD;
                            r_state <= ST_STALL;
                        end
                    end
                    ST_STALL: begin
                        if (exec_en_i) r_cnt <= r_cnt - CNT_W'(1);
                    end
                    ST_DONE: begin
                        r_state <= ST_IDLE;
                        r_pc    <= '0;
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign stall_o     = exec_en_i &&
                         (((r_state == ST_EXEC) && alu_stall_i) ||
                          ((r_state == ST_STALL) && (r_cnt != '0)));
    assign pc_o        = r_pc;
    assign res_o       = r_res;
    assign flag_o      = r_flag;
    assign res_valid_o = r_res_valid;
    assign busy_o      = (r_state == ST_EXEC) || (r_state == ST_STALL);
    assign done_o      = (r_state == ST_DONE);

endmodule

// File: tb/tb_rc_exec_ctrl.sv
// Bench for rc_exec_ctrl: two instances (multiply stall 1 and 3) share stimulus and are
// each compared every cycle against a kernel-level reference model.
module tb_rc_exec_ctrl;

    localparam int DW = 32;
    localparam int NF = 2;
    localparam int LG = 5;

    typedef struct {
        logic          rst;
        logic          start;
        logic          en;
        logic          last;
        logic          br;
        logic          stl;
        logic [LG-1:0] badd;
        logic [DW-1:0] res;
        logic [NF-1:0] fl;
    } stim_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start_i = 1'b0, exec_en_i = 1'b0, end_i = 1'b0;
    logic          br_req_i = 1'b0, alu_stall_i = 1'b0;
    logic [LG-1:0] br_add_i = '0;
    logic [DW-1:0] alu_res_i = '0;
    logic [NF-1:0] flag_i = '0;

    logic [LG-1:0] pc_o[2];
    logic [DW-1:0] res_o[2];
    logic [NF-1:0] flag_o[2];
    logic          res_valid_o[2], stall_o[2], busy_o[2], done_o[2];

    int n_chk = 0;
    int n_err = 0;

    // reference model: kernel running/finishing flags, remaining multiply cycles
    int            m_mult[2] = '{1, 3};
    bit            m_busy[2], m_done[2], m_rv[2];
    int            m_pc[2], m_hold[2];
    logic [DW-1:0] m_res[2];
    logic [NF-1:0] m_flag[2];
    logic [DW-1:0] exp_q_m1[$];
    logic [DW-1:0] exp_q_m3[$];

    always #5 clk = ~clk;

    rc_exec_ctrl #(.MULT_STALL_CYCLES(1)) u_m1 (
        .clk_i(clk), .rst_i(rst), .start_i(start_i), .exec_en_i(exec_en_i), .end_i(end_i),
        .alu_res_i(alu_res_i), .flag_i(flag_i), .br_req_i(br_req_i), .br_add_i(br_add_i),
        .alu_stall_i(alu_stall_i), .pc_o(pc_o[0]), .res_o(res_o[0]), .flag_o(flag_o[0]),
        .res_valid_o(res_valid_o[0]), .stall_o(stall_o[0]), .busy_o(busy_o[0]), .done_o(done_o[0])
    );

    rc_exec_ctrl #(.MULT_STALL_CYCLES(3)) u_m3 (
        .clk_i(clk), .rst_i(rst), .start_i(start_i), .exec_en_i(exec_en_i), .end_i(end_i),
        .alu_res_i(alu_res_i), .flag_i(flag_i), .br_req_i(br_req_i), .br_add_i(br_add_i),
        .alu_stall_i(alu_stall_i), .pc_o(pc_o[1]), .res_o(res_o[1]), .flag_o(flag_o[1]),
        .res_valid_o(res_valid_o[1]), .stall_o(stall_o[1]), .busy_o(busy_o[1]), .done_o(done_o[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic stim_t nop();
        stim_t s;
        s.rst = 1'b0; s.start = 1'b0; s.en = 1'b1; s.last = 1'b0; s.br = 1'b0;
        s.stl = 1'b0; s.badd = '0; s.res = '0; s.fl = '0;
        return s;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_busy[i] = 0; m_done[i] = 0; m_rv[i] = 0;
            m_pc[i] = 0; m_hold[i] = 0; m_res[i] = '0; m_flag[i] = '0;
        end
        exp_q_m1.delete();
        exp_q_m3.delete();
    endtask

    task automatic model_step(input int i, input stim_t s);
        bit commit;
        commit  = 0;
        m_rv[i] = 0;
        if (m_done[i]) begin
            m_done[i] = 0;
        end else if (!m_busy[i]) begin
            if (s.start) m_busy[i] = 1;
        end else if (s.en) begin
            if (m_hold[i] == 1) begin
                commit = 1; m_hold[i] = 0;
            end else if (m_hold[i] > 1) begin
                m_hold[i]--;
            end else if (s.stl) begin
                m_hold[i] = m_mult[i];
            end else begin
                commit = 1;
            end
            if (commit) begin
                m_rv[i] = 1; m_res[i] = s.res; m_flag[i] = s.fl;
                if (i == 0) exp_q_m1.push_back(s.res);
                else        exp_q_m3.push_back(s.res);
                if (s.last) begin
                    m_busy[i] = 0; m_done[i] = 1; m_pc[i] = 0;
                end else if (s.br) begin
                    m_pc[i] = int'(s.badd);
                end else begin
                    m_pc[i] = (m_pc[i] + 1) % 32;
                end
            end
        end
    endtask

    task automatic check_inst(input int i, input stim_t s);
        bit            exp_stall;
        logic [DW-1:0] sb;
        exp_stall = m_busy[i] && s.en && ((m_hold[i] == 0 && s.stl) || m_hold[i] > 1);
        check($sformatf("pc[%0d]", i),    32'(pc_o[i]),      32'(m_pc[i]));
        check($sformatf("res[%0d]", i),   res_o[i],          m_res[i]);
        check($sformatf("flag[%0d]", i),  32'(flag_o[i]),    32'(m_flag[i]));
        check($sformatf("rv[%0d]", i),    32'(res_valid_o[i]), 32'(m_rv[i]));
        check($sformatf("busy[%0d]", i),  32'(busy_o[i]),    32'(m_busy[i]));
        check($sformatf("done[%0d]", i),  32'(done_o[i]),    32'(m_done[i]));
        check($sformatf("stall[%0d]", i), 32'(stall_o[i]),   32'(exp_stall));
        if (res_valid_o[i] === 1'b1) begin
            if (i == 0) begin
                check("sb_avail[0]", 32'(exp_q_m1.size() != 0), 32'd1);
                if (exp_q_m1.size() != 0) begin
                    sb = exp_q_m1.pop_front();
                    check("sb_res[0]", res_o[0], sb);
                end
            end else begin
                check("sb_avail[1]", 32'(exp_q_m3.size() != 0), 32'd1);
                if (exp_q_m3.size() != 0) begin
                    sb = exp_q_m3.pop_front();
                    check("sb_res[1]", res_o[1], sb);
                end
            end
        end
    endtask

    task automatic cyc(input stim_t s);
        @(posedge clk);
        #1;
        rst = s.rst; start_i = s.start; exec_en_i = s.en; end_i = s.last;
        br_req_i = s.br; br_add_i = s.badd; alu_stall_i = s.stl;
        alu_res_i = s.res; flag_i = s.fl;
        @(negedge clk);
        if (s.rst) model_reset();
        for (int i = 0; i < 2; i++) begin
            check_inst(i, s);
            if (!s.rst) model_step(i, s);
        end
    endtask

    initial begin : main
        stim_t s;
        int    stall_cnt[2];
        int    commit_at[2];

        model_reset();
        // reset then idle
        s = nop(); s.rst = 1'b1;
        repeat (2) cyc(s);
        s = nop();
        repeat (3) cyc(s);
        check("idle_pc", 32'(pc_o[1]), 32'd0);

        // linear kernel 5,6,7
        s = nop(); s.start = 1'b1; cyc(s);
        s = nop(); s.res = 5; cyc(s);
        s.res = 6; cyc(s);
        s.res = 7; s.last = 1'b1; cyc(s);
        s = nop(); cyc(s);
        check("lin_done", 32'(done_o[1]), 32'd1);
        check("lin_res", res_o[1], 32'd7);
        cyc(s);
        check("lin_idle_busy", 32'(busy_o[0]), 32'd0);

        // branch to 31, wrap to 0, branch ignored under end
        s = nop(); s.start = 1'b1; cyc(s);
        s = nop(); s.res = 1; cyc(s);
        s = nop(); s.br = 1'b1; s.badd = 5'd31; cyc(s);
        s = nop(); cyc(s);
        check("br_pc31", 32'(pc_o[0]), 32'd31);
        s = nop(); s.br = 1'b1; s.badd = 5'd9; s.last = 1'b1; cyc(s);
        check("wrap_pc0", 32'(pc_o[0]), 32'd0);
        s = nop(); cyc(s);
        check("br_end_done", 32'(done_o[0]), 32'd1);
        check("br_end_pc", 32'(pc_o[0]), 32'd0);
        cyc(s);

        // multiply: stall 1 vs 3
        s = nop(); s.start = 1'b1; cyc(s);
        stall_cnt = '{0, 0}; commit_at = '{0, 0};
        for (int k = 1; k <= 5; k++) begin
            s = nop();
            if (k <= 4) begin
                s.stl = 1'b1; s.last = 1'b1; s.res = 32'hFFFF_FFFE; s.fl = 2'b10;
            end
            cyc(s);
            for (int i = 0; i < 2; i++) begin
                if (stall_o[i]) stall_cnt[i]++;
                if (res_valid_o[i]) commit_at[i] = k - 1;
            end
        end
        check("mul1_stalls", 32'(stall_cnt[0]), 32'd1);
        check("mul3_stalls", 32'(stall_cnt[1]), 32'd3);
        check("mul1_commit", 32'(commit_at[0]), 32'd2);
        check("mul3_commit", 32'(commit_at[1]), 32'd4);
        check("mul_res", res_o[1], 32'hFFFF_FFFE);
        check("mul_flag", 32'(flag_o[1]), 32'd2);

        // enable dropped for 2 cycles mid-stall
        s = nop(); s.start = 1'b1; cyc(s);
        stall_cnt = '{0, 0}; commit_at = '{0, 0};
        for (int k = 1; k <= 7; k++) begin
            s = nop();
            if (k <= 6) begin
                s.stl = 1'b1; s.last = 1'b1; s.res = 32'h1234; s.en = !(k == 3 || k == 4);
            end
            cyc(s);
            if (k == 3 || k == 4) check("dis_stall", 32'(stall_o[1]), 32'd0);
            if (stall_o[1]) stall_cnt[1]++;
            if (res_valid_o[1]) commit_at[1] = k - 1;
        end
        check("en_stalls", 32'(stall_cnt[1]), 32'd3);
        check("en_commit", 32'(commit_at[1]), 32'd6);

        // reset during stall
        s = nop(); s.start = 1'b1; cyc(s);
        s = nop(); s.stl = 1'b1; s.res = 32'hAA; cyc(s); cyc(s);
        s = nop(); s.rst = 1'b1; cyc(s);
        check("rst_busy", 32'(busy_o[1]), 32'd0);
        check("rst_res", res_o[1], 32'd0);
        s = nop(); cyc(s);

        // start while busy is ignored
        s = nop(); s.start = 1'b1; cyc(s);
        s = nop(); s.res = 1; cyc(s);
        s.start = 1'b1; s.res = 2; cyc(s);
        s = nop(); cyc(s);
        check("busy_start_pc", 32'(pc_o[0]), 32'd2);
        s.last = 1'b1; cyc(s);
        s = nop(); cyc(s); cyc(s);

        // randomized traffic
        for (int n = 0; n < 2500; n++) begin
            s.rst   = ($urandom_range(0, 99) < 1);
            s.start = ($urandom_range(0, 99) < 30);
            s.en    = ($urandom_range(0, 99) < 80);
            s.last  = ($urandom_range(0, 99) < 10);
            s.br    = ($urandom_range(0, 99) < 25);
            s.stl   = ($urandom_range(0, 99) < 25);
            s.badd  = LG'($urandom_range(0, 31));
            s.res   = $urandom;
            s.fl    = NF'($urandom_range(0, 3));
            cyc(s);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/rc_exec_ctrl.md
Name: rc_exec_ctrl

Overview:
Per-RC execution controller that consumes the ALU's result, flag, branch and stall outputs.
- Sequences the instruction pointer into the RC configuration register file.
- Commits ALU results and flags into architectural registers. The flags feed back to the ALU flag input.
- Holds the RC for multi-cycle multiplies.
- Reports kernel completion to the column controller.

Parameters:
DP_WIDTH, 32, datapath width
ALU_N_FLAG, 2, flag bits; bit1 = sign, bit0 = zero
RCS_NUM_CREG, 32, instruction slots (power of two)
RCS_NUM_CREG_LOG2, 5, log2(RCS_NUM_CREG)
MULT_STALL_CYCLES, 1, extra cycles a SMUL/FXPMUL occupies (>=1)

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset; asynchronous, active-high
start_i  in  1  kernel start pulse
exec_en_i  in  1  global advance enable; 0 freezes the block
end_i  in  1  current instruction is the kernel's last
alu_res_i  in  DP_WIDTH  ALU result
flag_i  in  ALU_N_FLAG  ALU flags (sign, zero)
br_req_i  in  1  ALU branch taken
br_add_i  in  RCS_NUM_CREG_LOG2  branch target
alu_stall_i  in  1  ALU executing multi-cycle multiply
pc_o  out  RCS_NUM_CREG_LOG2  instruction address
res_o  out  DP_WIDTH  committed result register
flag_o  out  ALU_N_FLAG  committed flag register, to ALU flag input
res_valid_o  out  1  one-cycle pulse per commit
stall_o  out  1  RC held by multiplier (combinational)
busy_o  out  1  kernel running
done_o  out  1  one-cycle completion pulse

Behaviour:
- Reset: all registers and outputs are 0, state=IDLE.
- Reset is asynchronous and takes effect immediately, including mid-kernel or mid-stall. No commit happens in that cycle.
- States:
  - IDLE: busy_o=0, pc_o=0. start_i=1 -> EXEC next cycle.
  - EXEC: busy_o=1. When exec_en_i=1:
    - alu_stall_i=0 -> commit.
    - alu_stall_i=1 -> no commit; stall_o=1; load cnt=MULT_STALL_CYCLES-1; -> STALL.
  - STALL: busy_o=1. When exec_en_i=1:
    - cnt!=0 -> cnt--, stall_o=1.
    - cnt==0 -> commit, stall_o=0, return to EXEC (or DONE).
    - A multiply therefore takes 1+MULT_STALL_CYCLES enabled cycles.
  - DONE: done_o=1 for exactly one cycle, busy_o=0, pc reset to 0; -> IDLE unconditionally.
- Commit (registered on the same edge):
  - res_o<=alu_res_i, flag_o<=flag_i, res_valid_o=1 in the following cycle.
  - Next PC:
    - end_i=1 -> DONE. end_i has priority over br_req_i; the branch is ignored.
    - else br_req_i=1 -> pc<=br_add_i.
    - else pc<=pc+1, wrapping modulo RCS_NUM_CREG (RCS_NUM_CREG-1 -> 0).
- exec_en_i=0: state, pc, cnt, res_o and flag_o all hold. stall_o=0 and res_valid_o=0 for that cycle.
- start_i outside IDLE: ignored.
- start_i in DONE: ignored; a new start must be issued in IDLE.
- res_o/flag_o keep their last committed values across DONE and IDLE until the next commit. They are not cleared by start_i.
- alu_stall_i/br_req_i/end_i/alu_res_i are sampled only in EXEC/STALL commit cycles. Inputs in IDLE/DONE are don't-care.
- During STALL, br_req_i/end_i/alu_res_i are taken from the final STALL cycle only.

Test Plan:
1. Reset, then idle 3 cycles -> pc_o=0, res_o=0, flag_o=0, busy_o=0, done_o=0, stall_o=0.
2. Linear run: start_i, ALU results 5,6,7 for pc 0,1,2, end_i at pc=2 -> pc_o 0,1,2; res_valid_o pulses 3 times; res_o=7; done_o high exactly one cycle after the third commit; then IDLE with pc_o=0.
3. Branch and wrap:
   - br_req_i=1, br_add_i=31 at pc=1 -> pc_o=31.
   - Next commit without branch -> pc_o=0.
   - Branch with end_i=1 -> DONE; target ignored.
4. Multiply stall, MULT_STALL_CYCLES=1 and 3, with alu_stall_i=1 -> stall_o high 1 and 3 cycles respectively. Commit of alu_res_i=0xFFFFFFFE with flag_i=2'b10 happens at cycle 2 and 4 respectively; pc holds meanwhile.
5. exec_en_i toggles 0 for 2 cycles mid-stall -> cnt, pc and stall state frozen; stall_o=0 while disabled; total enabled-cycle count unchanged.
6. Reset asserted during STALL, and start_i pulsed while busy:
   - Reset -> immediate return to reset values.
   - start_i while busy -> no restart; pc continues its sequence.
